sys_ctrl: RTL and testbench
===========================

// Module: sys_ctrl
// PURPOSE
// - Command sequencer that sits directly upstream of the ALU and drives its alu_en/alu_fun.
// - Parses byte frames from the UART RX path and performs register-file writes and reads.
// - For ALU frames, stores operands in RF[0] (A) and RF[1] (B), launches one ALU operation,
//   and sends the registered ALU result back through the UART TX path.
// PARAMETERS
// - DATA_WIDTH  8   byte / ALU operand width
// - ADDR_WIDTH  4   register-file address width
// PORTS
// - clk          in   1           system clock
// - rst          in   1           asynchronous, active-low reset
// - rx_data      in   DATA_WIDTH  received byte
// - rx_valid     in   1           one-cycle strobe; rx_data is valid
// - alu_out      in   DATA_WIDTH  ALU registered result
// - alu_valid    in   1           ALU out_valid
// - rf_rd_data   in   DATA_WIDTH  register-file read data
// - rf_rd_valid  in   1           register-file read data valid
// - tx_busy      in   1           UART TX is serialising a byte
// - alu_en       out  1           ALU enable, one-cycle pulse
// - alu_fun      out  4           ALU function code
// - clk_gate_en  out  1           enable for the ALU clock gate
// - rf_addr      out  ADDR_WIDTH  register-file address
// - rf_wr_en     out  1           register-file write strobe
// - rf_rd_en     out  1           register-file read strobe
// - rf_wr_data   out  DATA_WIDTH  register-file write data
// - tx_data      out  DATA_WIDTH  byte to transmit
// - tx_valid     out  1           one-cycle transmit strobe
// BEHAVIOUR
// - Reset: every output is 0; FSM state is IDLE; held-result register is 0.
// - Frames, one byte per rx_valid:
//   - 0xAA addr data -> RF write
//   - 0xBB addr      -> RF read, then TX of the read data
//   - 0xCC A B fun   -> write RF[0]=A, write RF[1]=B, ALU op, TX of the result
//   - 0xDD fun       -> ALU op on the current RF[0]/RF[1], TX of the result
// - States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_EXEC, ALU_WAIT, TX.
// - IDLE: a command byte selects the next state:
//   - 0xAA -> WR_ADDR
//   - 0xBB -> RD_ADDR
//   - 0xCC -> OPA
//   - 0xDD -> FUN
//   - any other byte is discarded; the FSM stays in IDLE.
// - Address bytes: rf_addr = byte[ADDR_WIDTH-1:0]; the upper bits are ignored.
// - WR_DATA: on rx_valid, rf_wr_en=1 for one cycle with the latched address and the data
//   byte -> IDLE.
// - RD_ADDR: on rx_valid, rf_rd_en=1 for one cycle -> RD_WAIT.
// - RD_WAIT: hold until rf_rd_valid; capture rf_rd_data -> TX.
// - OPA: on rx_valid, write RF[0] -> OPB.
// - OPB: on rx_valid, write RF[1] -> FUN.
// - FUN: on rx_valid, latch alu_fun = byte[3:0] -> ALU_EXEC.
// - ALU_EXEC: alu_en=1 for exactly one cycle -> ALU_WAIT.
// - ALU_WAIT: hold until alu_valid; capture alu_out -> TX. The ALU latency is 1 cycle.
// - clk_gate_en is 1 in FUN, ALU_EXEC and ALU_WAIT, and 0 in all other states.
// - TX: wait while tx_busy=1. When tx_busy=0, tx_valid=1 for one cycle with
//   tx_data = held result -> IDLE.
// - Transmit latency is 1 cycle when the UART TX is idle.
// - rx_valid received in RD_WAIT, ALU_EXEC, ALU_WAIT or TX is dropped; no queueing.
// - All strobes (alu_en, rf_wr_en, rf_rd_en, tx_valid) are registered single-cycle pulses
//   and are never asserted together.
// - rf_addr, rf_wr_data, alu_fun and tx_data hold their last value between strobes.
// - Reset mid-frame: all outputs return to 0 asynchronously; the partial frame is lost.
// - Result width is DATA_WIDTH only; the upper bits of A*B are already truncated by the ALU.
// STRUCTURE
// - Shared package holds:
//   - command constants CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD
//   - the ALU function code constants
//   - the state enum
//   - fixed operand addresses OPA_ADDR=0, OPB_ADDR=1
// - Single module; no sub-modules. Structure is a next-state block plus registered outputs.
// TESTING
// - RF write: bytes AA,05,3C -> rf_wr_en pulse with rf_addr=5, rf_wr_data=3C; then no tx_valid.
// - RF read: bytes BB,05; rf_rd_data=3C returned 1 cycle later -> one tx_valid pulse,
//   tx_data=3C.
// - ALU with operands: bytes CC,07,03,00 -> RF[0]=07, RF[1]=03, one alu_en pulse with
//   alu_fun=0; ALU returns 0A -> tx_data=0A.
// - ALU without operands, TX busy: bytes DD,02 with tx_busy=1 for 20 cycles -> tx_valid
//   only after tx_busy falls, exactly one pulse.
// - Unknown command and dropped bytes: bytes 55, then a byte during ALU_WAIT -> no strobes;
//   the FSM returns to IDLE and the next AA frame works.
// - Reset mid-frame: rst low after AA,05 -> all outputs 0; then BB,05 completes normally.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl shared definitions: command bytes,
// ALU function codes, fixed operand addresses, FSM states.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_MUL  = 4'h2;
  localparam logic [3:0] ALU_DIV  = 4'h3;
  localparam logic [3:0] ALU_AND  = 4'h4;
  localparam logic [3:0] ALU_OR   = 4'h5;
  localparam logic [3:0] ALU_NAND = 4'h6;
  localparam logic [3:0] ALU_NOR  = 4'h7;
  localparam logic [3:0] ALU_XOR  = 4'h8;
  localparam logic [3:0] ALU_XNOR = 4'h9;
  localparam logic [3:0] ALU_EQ   = 4'hA;
  localparam logic [3:0] ALU_GT   = 4'hB;
  localparam logic [3:0] ALU_LT   = 4'hC;
  localparam logic [3:0] ALU_SHR  = 4'hD;
  localparam logic [3:0] ALU_SHL  = 4'hE;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OPA,
    OPB,
    FUN,
    ALU_EXEC,
    ALU_WAIT,
    TX
  } state_t;

endpackage

// File: rtl/sys_ctrl.sv
// UART command sequencer: parses RX frames into
// register-file accesses and ALU operations, returns results on TX.
import sys_ctrl_pkg::*;

module sys_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_valid,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  input  logic                  tx_busy,
  output logic                  alu_en,
  output logic [3:0]            alu_fun,
  output logic                  clk_gate_en,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid
);

  state_t state, next;

  logic [DATA_WIDTH-1:0] result, result_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d, txd_d;
  logic [3:0]            fun_d;
  logic                  wr_d, rd_d, en_d, txv_d, gate_d;

  // next state plus next values of every registered output
  always_comb begin
    next     = state;
    addr_d   = rf_addr;
    wdata_d  = rf_wr_data;
    fun_d    = alu_fun;
    txd_d    = tx_data;
    result_d = result;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    en_d     = 1'b0;
    txv_d    = 1'b0;
    unique case (state)
      IDLE: if (rx_valid) begin
        unique case (1'b1)
          (rx_data == DATA_WIDTH'(CMD_WR)):      next = WR_ADDR;
          (rx_data == DATA_WIDTH'(CMD_RD)):      next = RD_ADDR;
          (rx_data == DATA_WIDTH'(CMD_ALU_OP)):  next = OPA;
          (rx_data == DATA_WIDTH'(CMD_ALU_NOP)): next = FUN;
          default:                               next = IDLE;
        endcase
      end
      WR_ADDR: if (rx_valid) begin
        addr_d = rx_data[ADDR_WIDTH-1:0];
        next   = WR_DATA;
      end
      WR_DATA: if (rx_valid) begin
        wdata_d = rx_data;
        wr_d    = 1'b1;
        next    = IDLE;
      end
      RD_ADDR: if (rx_valid) begin
        addr_d = rx_data[ADDR_WIDTH-1:0];
        rd_d   = 1'b1;
        next   = RD_WAIT;
      end
      RD_WAIT: if (rf_rd_valid) begin
        result_d = rf_rd_data;
        next     = TX;
      end
      OPA: if (rx_valid) begin
        addr_d  = ADDR_WIDTH'(OPA_ADDR);
        wdata_d = rx_data;
        wr_d    = 1'b1;
        next    = OPB;
      end
      OPB: if (rx_valid) begin
        addr_d  = ADDR_WIDTH'(OPB_ADDR);
        wdata_d = rx_data;
        wr_d    = 1'b1;
        next    = FUN;
      end
      FUN: if (rx_valid) begin
        fun_d = rx_data[3:0];
        en_d  = 1'b1;
        next  = ALU_EXEC;
      end
      ALU_EXEC: next = ALU_WAIT;
      ALU_WAIT: if (alu_valid) begin
        result_d = alu_out;
        next     = TX;
      end
      TX: if (!tx_busy) begin
        txd_d = result;
        txv_d = 1'b1;
        next  = IDLE;
      end
      default: next = IDLE;
    endcase
    gate_d = (next == FUN) || (next == ALU_EXEC)
          || (next == ALU_WAIT);
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  // registered outputs and held result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result      <= '0;
      rf_addr     <= '0;
      rf_wr_data  <= '0;
      alu_fun     <= '0;
      tx_data     <= '0;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      alu_en      <= 1'b0;
      tx_valid    <= 1'b0;
      clk_gate_en <= 1'b0;
    end else begin
      result      <= result_d;
      rf_addr     <= addr_d;
      rf_wr_data  <= wdata_d;
      alu_fun     <= fun_d;
      tx_data     <= txd_d;
      rf_wr_en    <= wr_d;
      rf_rd_en    <= rd_d;
      alu_en      <= en_d;
      tx_valid    <= txv_d;
      clk_gate_en <= gate_d;
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: drives RX frames,
// models RF read and ALU responders, checks strobes and TX bytes.
module tb_sys_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] alu_out;
  logic       alu_valid;
  logic [7:0] rf_rd_data;
  logic       rf_rd_valid;
  logic       tx_busy;
  logic       alu_en;
  logic [3:0] alu_fun;
  logic       clk_gate_en;
  logic [3:0] rf_addr;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [7:0] rf_wr_data;
  logic [7:0] tx_data;
  logic       tx_valid;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, tx_cnt = 0;
  int overlap = 0;
  int rd_cyc = 0, alu_cyc = 0, tx_cyc = 0;
  logic [3:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [3:0] rd_addr_l = '0;
  logic [3:0] fun_l = '0;
  logic [7:0] tx_l = '0;
  logic       gate_at_alu = 1'b0;
  bit         alu_auto = 1'b1;
  logic [7:0] alu_resp = '0;
  logic [7:0] rd_resp = '0;

  sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_out(alu_out), .alu_valid(alu_valid),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .tx_busy(tx_busy),
    .alu_en(alu_en), .alu_fun(alu_fun),
    .clk_gate_en(clk_gate_en),
    .rf_addr(rf_addr), .rf_wr_en(rf_wr_en),
    .rf_rd_en(rf_rd_en), .rf_wr_data(rf_wr_data),
    .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  // strobe monitor, sampled shortly after each rising edge
  always @(posedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      if (int'(alu_en) + int'(rf_wr_en) + int'(rf_rd_en)
          + int'(tx_valid) > 1) overlap++;
      if (rf_wr_en) begin
        wr_cnt++;
        wr_addr_q.push_back(rf_addr);
        wr_data_q.push_back(rf_wr_data);
      end
      if (rf_rd_en) begin
        rd_cnt++;
        rd_addr_l = rf_addr;
        rd_cyc = cyc;
      end
      if (alu_en) begin
        alu_cnt++;
        fun_l = alu_fun;
        gate_at_alu = clk_gate_en;
        alu_cyc = cyc;
      end
      if (tx_valid) begin
        tx_cnt++;
        tx_l = tx_data;
        tx_cyc = cyc;
      end
    end
  end

  // ALU model: result valid one cycle after alu_en
  always @(posedge clk) begin
    #2;
    if (rst && alu_en && alu_auto) begin
      @(posedge clk); #1;
      alu_out = alu_resp;
      alu_valid = 1'b1;
      @(posedge clk); #1;
      alu_valid = 1'b0;
    end
  end

  // RF model: read data valid one cycle after rf_rd_en
  always @(posedge clk) begin
    #2;
    if (rst && rf_rd_en) begin
      @(posedge clk); #1;
      rf_rd_data = rd_resp;
      rf_rd_valid = 1'b1;
      @(posedge clk); #1;
      rf_rd_valid = 1'b0;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int base, input int lim);
    for (int i = 0; i < lim && tx_cnt == base; i++)
      @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rx_data = '0; rx_valid = 1'b0;
    alu_out = '0; alu_valid = 1'b0;
    rf_rd_data = '0; rf_rd_valid = 1'b0;
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({alu_en, alu_fun, clk_gate_en, rf_addr, rf_wr_en,
         rf_rd_en, rf_wr_data, tx_data, tx_valid} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h %h %h %h %h %h %h %h %h want all 0",
               alu_en, alu_fun, clk_gate_en, rf_addr, rf_wr_en,
               rf_rd_en, rf_wr_data, tx_data, tx_valid);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rf_write;
    int w0, r0, t0;
    w0 = wr_cnt; r0 = rd_cnt; t0 = tx_cnt;
    send(8'hAA); send(8'h05); send(8'h3C);
    repeat (6) @(negedge clk);
    total++;
    if (wr_cnt - w0 !== 1) begin
      bad++;
      $display("FAIL wr_count: got %0d want 1", wr_cnt - w0);
    end
    total++;
    if (wr_addr_q[w0] !== 4'h5 || wr_data_q[w0] !== 8'h3C) begin
      bad++;
      $display("FAIL wr_fields: got addr=%h data=%h want 5 3c",
               wr_addr_q[w0], wr_data_q[w0]);
    end
    total++;
    if (tx_cnt - t0 !== 0 || rd_cnt - r0 !== 0) begin
      bad++;
      $display("FAIL wr_no_tx: got tx=%0d rd=%0d want 0 0",
               tx_cnt - t0, rd_cnt - r0);
    end
    total++;
    if (rf_addr !== 4'h5) begin
      bad++;
      $display("FAIL wr_addr_hold: got %h want 5", rf_addr);
    end
  endtask

  task automatic test_rf_read;
    int r0, t0;
    r0 = rd_cnt; t0 = tx_cnt;
    rd_resp = 8'h3C;
    send(8'hBB); send(8'h05);
    wait_tx(t0, 40);
    repeat (3) @(negedge clk);
    total++;
    if (rd_cnt - r0 !== 1 || rd_addr_l !== 4'h5) begin
      bad++;
      $display("FAIL rd_strobe: got cnt=%0d addr=%h want 1 5",
               rd_cnt - r0, rd_addr_l);
    end
    total++;
    if (tx_cnt - t0 !== 1 || tx_l !== 8'h3C) begin
      bad++;
      $display("FAIL rd_tx: got cnt=%0d data=%h want 1 3c",
               tx_cnt - t0, tx_l);
    end
    total++;
    if (tx_cyc - rd_cyc !== 3) begin
      bad++;
      $display("FAIL rd_latency: got %0d want 3", tx_cyc - rd_cyc);
    end
  endtask

  task automatic test_alu_op;
    int w0, a0, t0;
    w0 = wr_cnt; a0 = alu_cnt; t0 = tx_cnt;
    alu_resp = 8'h0A;
    send(8'hCC); send(8'h07); send(8'h03); send(8'h00);
    wait_tx(t0, 40);
    repeat (3) @(negedge clk);
    total++;
    if (wr_cnt - w0 !== 2) begin
      bad++;
      $display("FAIL op_wr_count: got %0d want 2", wr_cnt - w0);
    end
    total++;
    if (wr_addr_q[w0] !== 4'h0 || wr_data_q[w0] !== 8'h07
        || wr_addr_q[w0+1] !== 4'h1 || wr_data_q[w0+1] !== 8'h03) begin
      bad++;
      $display("FAIL op_writes: got %h:%h %h:%h want 0:07 1:03",
               wr_addr_q[w0], wr_data_q[w0],
               wr_addr_q[w0+1], wr_data_q[w0+1]);
    end
    total++;
    if (alu_cnt - a0 !== 1 || fun_l !== 4'h0 || gate_at_alu !== 1'b1) begin
      bad++;
      $display("FAIL op_alu_en: got cnt=%0d fun=%h gate=%b want 1 0 1",
               alu_cnt - a0, fun_l, gate_at_alu);
    end
    total++;
    if (tx_cnt - t0 !== 1 || tx_l !== 8'h0A) begin
      bad++;
      $display("FAIL op_tx: got cnt=%0d data=%h want 1 0a",
               tx_cnt - t0, tx_l);
    end
    total++;
    if (tx_cyc - alu_cyc !== 3) begin
      bad++;
      $display("FAIL op_latency: got %0d want 3", tx_cyc - alu_cyc);
    end
    total++;
    if (clk_gate_en !== 1'b0) begin
      bad++;
      $display("FAIL op_gate_idle: got %b want 0", clk_gate_en);
    end
  endtask

  task automatic test_tx_busy;
    int w0, a0, t0;
    w0 = wr_cnt; a0 = alu_cnt; t0 = tx_cnt;
    alu_resp = 8'h5A;
    tx_busy = 1'b1;
    send(8'hDD); send(8'h02);
    repeat (20) @(negedge clk);
    total++;
    if (tx_cnt - t0 !== 0) begin
      bad++;
      $display("FAIL busy_hold: got %0d tx while busy want 0", tx_cnt - t0);
    end
    total++;
    if (alu_cnt - a0 !== 1 || fun_l !== 4'h2 || wr_cnt - w0 !== 0) begin
      bad++;
      $display("FAIL nop_alu: got cnt=%0d fun=%h wr=%0d want 1 2 0",
               alu_cnt - a0, fun_l, wr_cnt - w0);
    end
    tx_busy = 1'b0;
    wait_tx(t0, 10);
    repeat (5) @(negedge clk);
    total++;
    if (tx_cnt - t0 !== 1 || tx_l !== 8'h5A) begin
      bad++;
      $display("FAIL busy_release: got cnt=%0d data=%h want 1 5a",
               tx_cnt - t0, tx_l);
    end
  endtask

  task automatic test_drop;
    int w0, r0, a0, t0;
    w0 = wr_cnt; r0 = rd_cnt; a0 = alu_cnt; t0 = tx_cnt;
    alu_auto = 1'b0;
    send(8'h55);
    repeat (4) @(negedge clk);
    total++;
    if ((wr_cnt - w0) + (rd_cnt - r0) + (alu_cnt - a0)
        + (tx_cnt - t0) !== 0 || clk_gate_en !== 1'b0) begin
      bad++;
      $display("FAIL unknown_cmd: got strobes=%0d gate=%b want 0 0",
               (wr_cnt - w0) + (rd_cnt - r0) + (alu_cnt - a0)
               + (tx_cnt - t0), clk_gate_en);
    end
    send(8'hDD); send(8'h01);
    send(8'hAA);
    @(negedge clk);
    alu_out = 8'h11;
    alu_valid = 1'b1;
    @(negedge clk);
    alu_valid = 1'b0;
    wait_tx(t0, 20);
    repeat (2) @(negedge clk);
    total++;
    if (tx_cnt - t0 !== 1 || tx_l !== 8'h11) begin
      bad++;
      $display("FAIL drop_tx: got cnt=%0d data=%h want 1 11",
               tx_cnt - t0, tx_l);
    end
    send(8'hAA); send(8'h03); send(8'h77);
    repeat (4) @(negedge clk);
    total++;
    if (wr_cnt - w0 !== 1 || wr_addr_q[w0] !== 4'h3
        || wr_data_q[w0] !== 8'h77) begin
      bad++;
      $display("FAIL after_drop_wr: got cnt=%0d %h:%h want 1 3:77",
               wr_cnt - w0, wr_addr_q[w0], wr_data_q[w0]);
    end
    total++;
    if (tx_data !== 8'h11) begin
      bad++;
      $display("FAIL tx_data_hold: got %h want 11", tx_data);
    end
    alu_auto = 1'b1;
  endtask

  task automatic test_reset_mid;
    int w0, t0;
    send(8'hAA); send(8'h05);
    #1;
    total++;
    if (rf_addr !== 4'h5) begin
      bad++;
      $display("FAIL mid_addr: got %h want 5", rf_addr);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({alu_en, alu_fun, clk_gate_en, rf_addr, rf_wr_en,
         rf_rd_en, rf_wr_data, tx_data, tx_valid} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got addr=%h wdata=%h txd=%h want 0",
               rf_addr, rf_wr_data, tx_data);
    end
    @(negedge clk);
    rst = 1'b1;
    w0 = wr_cnt; t0 = tx_cnt;
    rd_resp = 8'h3C;
    send(8'hBB); send(8'h05);
    wait_tx(t0, 40);
    repeat (3) @(negedge clk);
    total++;
    if (tx_cnt - t0 !== 1 || tx_l !== 8'h3C || wr_cnt - w0 !== 0) begin
      bad++;
      $display("FAIL post_reset_rd: got cnt=%0d data=%h wr=%0d want 1 3c 0",
               tx_cnt - t0, tx_l, wr_cnt - w0);
    end
  endtask

  task automatic test_exclusive;
    total++;
    if (overlap !== 0) begin
      bad++;
      $display("FAIL strobe_overlap: got %0d cycles want 0", overlap);
    end
  endtask

  initial begin
    test_reset;
    test_rf_write;
    test_rf_read;
    test_alu_op;
    test_tx_busy;
    test_drop;
    test_reset_mid;
    test_exclusive;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
